// File: rtl/uart_rx_core.sv
// uart_rx_core: asynchronous serial receiver (8N1, or 8E1 when UART_RX_PARITY_EN
// is defined). rxd is synchronized, sampled at mid-bit by a down-counting
// bit timer, reassembled LSB-first and handed out through a valid/ready
// holding register.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rxd        raw serial input, idle high
//   rx_data    received byte (LSB = first data bit on the wire)
//   rx_valid   rx_data holds an unconsumed byte
//   rx_ready   consumer accepts rx_data when rx_valid && rx_ready
//   busy       high from start-bit detection until return to IDLE
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    one-cycle pulse when a completed byte is dropped
//   parity_err one-cycle pulse on even-parity mismatch (UART_RX_PARITY_EN only)
//
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state and parity_err).
module uart_rx_core #(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_nxt;
    logic [BW-1:0]          r_bit_idx;
    logic [BW-1:0]          w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_tick;
    logic                   w_deliver;
    logic                   w_frame_bad;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_err;
    logic                   w_parity_bad;
`endif

    assign w_tick = (r_timer == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, timer, bit index and shift register updates
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_tick ? '0 : (r_timer - TW'(1));
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_bad = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt = S_START;
                    w_timer_nxt = HALF_LOAD;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        // Line went back high before mid-start: a glitch.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_timer_nxt = FULL_LOAD;
                        w_bit_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // Right shift: after DATA_BITS samples the first bit sits in the LSB.
                    w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit_idx + BW'(1);
                    w_timer_nxt = FULL_LOAD;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    // Even parity: line bit must equal XOR of the data bits.
                    w_parity_bad = (r_sync2 != (^r_shift));
                    w_timer_nxt  = FULL_LOAD;
                    w_state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold here through a long low so it reports only one error.
                if (r_sync2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Synchronizer, datapath and output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_timer     <= w_timer_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_deliver && r_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_bad;
`endif
            if (w_deliver) begin
                // A simultaneous accept frees the register for the new byte.
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Asynchronous serial receiver: the receive end of the team's 8N1/8E1 UART link, paired with the transmit-side UART example.
- Samples `rxd` at mid-bit using a clock-cycle bit timer and reassembles LSB-first frames.
- Delivers each byte through a valid/ready holding register.
- Sits between a board pin and any byte-stream consumer, such as a FIFO or command parser.

Parameters:
- CLK_PER_BIT, 16: clock cycles per bit period; legal range ≥ 4.
- DATA_BITS, 8: data bits per frame; legal range 5–9.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- rxd  in  1  raw serial input; idle high; asynchronous to clk.
- rx_data  out  DATA_BITS  received byte, LSB = first data bit on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- busy  out  1  high from start-bit detection until return to IDLE.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset values:
  - Synchronizer flops: 1.
  - rx_data = 0, rx_valid = 0, busy = 0, frame_err = 0, overrun = 0.
  - State = IDLE; counters = 0.
- Input sync: 2-flop synchronizer on rxd. All decisions use the second flop (rxd_s).
- Bit timer:
  - Down-counter of width clog2(CLK_PER_BIT).
  - Sample point is when the counter reaches 0.
- IDLE:
  - On rxd_s == 0: go to START, load timer with CLK_PER_BIT/2 − 1 (integer divide), assert busy.
- START (sample at half bit):
  - rxd_s == 1: false start; return to IDLE with no outputs.
  - rxd_s == 0: load CLK_PER_BIT − 1, clear bit index, go to DATA.
- DATA:
  - At each sample, shift rxd_s into the MSB of the shift register (right shift), increment the bit index, reload the timer.
  - After DATA_BITS samples, go to PARITY if the feature is enabled, else STOP.
- STOP:
  - At sample, rxd_s == 1: frame good; go to IDLE and deliver.
  - At sample, rxd_s == 0: pulse frame_err, discard the byte, go to BREAK.
- BREAK:
  - Wait for rxd_s == 1, then go to IDLE. Continuous low never produces repeated frame_err or bytes.
- Delivery:
  - Occurs on the clock edge after the good stop-bit sample. The state returns to IDLE on that same edge.
  - busy deasserts on that same edge.
- Delivery cases (evaluated on the delivery edge):
  - rx_valid == 0: load rx_data, set rx_valid.
  - rx_valid == 1 && rx_ready == 1: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid == 1 && rx_ready == 0: keep the old byte, pulse overrun.
- Handshake:
  - rx_valid clears on the edge where rx_valid && rx_ready and no delivery occurs.
  - rx_data is stable while rx_valid && !rx_ready.
- Back-to-back frames: IDLE can detect a new start bit on the cycle after delivery.
- Reset mid-frame: abort immediately; the partial byte is lost; outputs go to reset values.
- Latency: rx_valid rises 2 (sync) + CLK_PER_BIT/2 + (DATA_BITS + 1)·CLK_PER_BIT + 1 cycles after the rxd falling edge (±1 for sync phase).
  - With the feature enabled, add CLK_PER_BIT.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY after DATA, sampled one bit period later.
  - Even parity: expected bit = XOR of the data bits.
  - Adds output port parity_err (1 bit, reset 0), pulsed for one cycle on mismatch at the parity sample.
  - A mismatched byte is still delivered with normal handshake and overrun rules.
  - Frame becomes start + DATA_BITS + parity + stop.
- Undefined: no PARITY state, no parity_err port; frame is start + DATA_BITS + stop.

Test Plan:
- Basic frame, rx_ready tied 1: CLK_PER_BIT = 16, send 0xA5 (wire bits 0,1,0,1,0,0,1,0,1,1) -> rx_valid for 1 cycle with rx_data = 0xA5; busy high for ≈152 cycles; no error pulses.
- Glitch rejection: rxd low for 5 cycles, then high -> return to IDLE at the half-bit check; rx_valid, frame_err and overrun stay 0.
- Framing error: send 0x3C with stop bit = 0, hold low 40 cycles, then idle -> exactly one frame_err pulse; no rx_valid; next 0x55 is received correctly.
- Overrun and simultaneous accept:
  - Send 0x11 then 0x22 back-to-back, rx_ready = 0 -> overrun pulse on the second delivery; rx_data = 0x11.
  - Repeat with rx_ready = 1 only on the second delivery edge -> rx_data = 0x22, rx_valid stays 1, no overrun.
- Reset mid-frame: assert rst_n low during data bit 4 of 0xFF -> all outputs 0 asynchronously; after release, a full 0x81 frame is received correctly.
- Parity (UART_RX_PARITY_EN defined):
  - 0x07 with parity bit 1 -> no parity_err; delivered.
  - 0x07 with parity bit 0 -> parity_err pulse; 0x07 still delivered.
